rxuart_fifo_free: RTL and testbench
===================================

Name: rxuart_fifo_free

Overview:
- 8N1 asynchronous serial receiver, 115200 baud from a 16 MHz clock; the receive-side counterpart of the team's UART transmitter.
- Oversamples the RX line at 16x using a fractional phase accumulator, validates the start bit and majority-votes each bit.
- Presents each byte in a single holding register with a valid/read handshake, plus framing-error and overrun reporting.
- Sits between the board RX pin and the consuming logic (echo/loopback, command parser).

Parameters:
- BAUD_INC, 144: accumulator increment per i_clk. 16e6*144/1250 = 1.8432 MHz = 16 x 115200.
- BAUD_MOD, 1250: accumulator modulus.
- ACC_W, 12: accumulator width. Must hold BAUD_MOD-1+BAUD_INC.

Ports:
- i_clk, input, 1: system clock, 16 MHz. All logic is on the rising edge.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_uart_rx, input, 1: serial line, asynchronous to i_clk. Idles high.
- i_read, input, 1: consumer acknowledges o_data. Effective only while o_valid=1.
- o_data, output, 8: last received byte.
- o_valid, output, 1: o_data holds an unread byte.
- o_frame_err, output, 1: one-cycle pulse when a stop bit is sampled 0.
- o_overrun, output, 1: sticky. An unread byte was overwritten.
- o_busy, output, 1: receiver FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - FSM=IDLE, accumulator=0, tick counter=0.
  - Synchronizer flops = 1.
  - Reset mid-frame abandons the frame. No partial byte is ever delivered.
- Synchronizer: two flops on i_uart_rx. All decisions use the second flop (rxs).
- Tick generator:
  - Each clock, acc <= acc+BAUD_INC.
  - When acc+BAUD_INC >= BAUD_MOD, acc <= acc+BAUD_INC-BAUD_MOD and tick=1 for that cycle.
  - The generator free-runs and is never reset by the FSM.
  - Mean tick spacing is 8.68 clocks; one bit is 16 ticks.
- Bit timing:
  - A 4-bit sub-bit counter cnt advances on each tick.
  - Samples are taken at cnt=7,8,9. The bit value is the majority of the three.
  - The bit decision is made on the cnt=9 tick.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on a tick with rxs=0, go to START with cnt=1 (that tick is cnt=0).
  - START: at the cnt=9 decision:
    - vote=1 (glitch): go to IDLE, nothing is reported.
    - vote=0: continue. On cnt wrap 15->0, go to DATA with bit index 0.
  - DATA:
    - Each bit decision shifts the vote into the shift register, LSB first.
    - After bit index 7 wraps, go to STOP.
  - STOP: at the decision:
    - vote=1: deliver the byte and go to IDLE immediately, without waiting out the stop bit. This allows back-to-back frames.
    - vote=0: o_frame_err=1 for exactly one clock, byte discarded, go to BREAK.
  - BREAK: stay until a tick with rxs=1, then go to IDLE.
  - o_busy = (state != IDLE), registered.
- Delivery, one clock after the stop decision:
  - o_data <= shift register, o_valid <= 1.
  - If o_valid was already 1 and i_read=0 in the delivery cycle: o_overrun <= 1 and o_data is overwritten by the newer byte.
- i_read with o_valid=1: next cycle o_valid=0 and o_overrun=0.
- Simultaneous i_read and delivery: the new byte loads, o_valid stays 1, o_overrun is not set (it clears if previously set).
- i_read with o_valid=0 has no effect.
- o_frame_err never sets o_valid and does not alter o_data.

Test Plan:
- Single byte: drive 0x48 ('H') 8N1 at 138.9 clks/bit. Required: o_valid rises about 9/16 bit after the stop-bit start, o_data=0x48, o_busy falls the same cycle. i_read=1 for one clock gives o_valid=0 the next cycle.
- Glitch rejection: pull RX low for 20 clocks, then high. Required: o_busy pulses, no o_valid, no o_frame_err, FSM back in IDLE before cnt=10.
- Framing error: send 0x55 with stop bit=0, hold low for 3 bit-times, then release. Required: one-cycle o_frame_err, o_valid stays 0, o_busy stays 1 until the line returns high. A following 0x55 with a good stop is received correctly.
- Overrun and simultaneity:
  - Send 0x41 then 0x42, no read. Required: o_data=0x42, o_overrun=1. i_read clears both o_valid and o_overrun.
  - Repeat with i_read asserted exactly on the 0x42 delivery cycle. Required: o_valid=1, o_overrun=0.
- Reset mid-frame: assert i_rst_n=0 during data bit 3 of 0xA5. Required: all outputs 0 immediately and no byte delivered. After release, 0x65 ('e') is received correctly.
- Stream:
  - Back-to-back "Hello, world! " (14 bytes, then 0x00), stop bits of exactly 1 bit-time, consumer reads on each o_valid. Required: all 15 bytes in order, zero framing errors, zero overruns.
  - Repeat at +/-2% baud skew with the same result.

Source files
------------

// File: rtl/rxuart_fifo_free_if.sv
// rtl/rxuart_fifo_free_if.sv - byte handshake and status bundle between the UART receiver and its consumer
interface rxuart_fifo_free_if;
  logic       i_read;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  modport master (
    input  i_read,
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_overrun,
    output o_busy
  );

  modport slave (
    output i_read,
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_overrun,
    input  o_busy
  );
endinterface

// File: rtl/rxuart_fifo_free.sv
// rtl/rxuart_fifo_free.sv - 8N1 UART receiver with 16x fractional oversampling and a single holding register
module rxuart_fifo_free #(
  parameter int BAUD_INC = 144,
  parameter int BAUD_MOD = 1250,
  parameter int ACC_W    = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_uart_rx,
  rxuart_fifo_free_if.master        bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  localparam logic [ACC_W:0] INC_W = (ACC_W+1)'(BAUD_INC);
  localparam logic [ACC_W:0] MOD_W = (ACC_W+1)'(BAUD_MOD);

  state_t           state;
  state_t           state_next;
  logic             rx_meta;
  logic             rxs;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W:0]   acc_wrap;
  logic             tick;
  logic [3:0]       cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             samp7;
  logic             samp8;
  logic             vote;
  logic             decide;
  logic             deliver;
  logic             frame_bad;

  // Two-flop synchronizer; reset to the idle (mark) level so no false start is seen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rxs     <= rx_meta;
    end
  end

  // Fractional accumulator: a tick fires whenever the sum crosses the modulus.
  always_comb begin
    acc_sum  = {1'b0, acc} + INC_W;
    acc_wrap = acc_sum - MOD_W;
    tick     = (acc_sum >= MOD_W);
    acc_next = tick ? acc_wrap[ACC_W-1:0] : acc_sum[ACC_W-1:0];
  end

  // Free-running tick generator; the FSM never restarts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) acc <= '0;
    else          acc <= acc_next;
  end

  assign vote   = (samp7 & samp8) | (samp7 & rxs) | (samp8 & rxs);
  assign decide = tick && (cnt == 4'd9);

  // Sub-bit counter, mid-bit samples and LSB-first shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      samp7   <= 1'b1;
      samp8   <= 1'b1;
    end else if (tick) begin
      if (state == S_IDLE) begin
        cnt     <= rxs ? 4'd0 : 4'd1;
        bit_idx <= '0;
      end else begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd7) samp7 <= rxs;
        if (cnt == 4'd8) samp8 <= rxs;
        if (state == S_DATA && cnt == 4'd9)  shift   <= {vote, shift[7:1]};
        if (state == S_DATA && cnt == 4'd15) bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // FSM next-state logic; the stop bit is not waited out so frames can abut.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (tick && !rxs) state_next = S_START;
      S_START: begin
        if (decide && vote)                    state_next = S_IDLE;
        else if (tick && cnt == 4'd15)         state_next = S_DATA;
      end
      S_DATA:  if (tick && cnt == 4'd15 && bit_idx == 3'd7) state_next = S_STOP;
      S_STOP:  if (decide) state_next = vote ? S_IDLE : S_BREAK;
      S_BREAK: if (tick && rxs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: stop-bit verdict.
  always_comb begin
    deliver   = 1'b0;
    frame_bad = 1'b0;
    if (state == S_STOP && decide) begin
      deliver   = vote;
      frame_bad = !vote;
    end
  end

  // Holding register with read handshake, overrun tracking and status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_data      <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_frame_err <= 1'b0;
      bus.o_overrun   <= 1'b0;
      bus.o_busy      <= 1'b0;
    end else begin
      bus.o_busy      <= (state_next != S_IDLE);
      bus.o_frame_err <= frame_bad;
      if (deliver) begin
        bus.o_data    <= shift;
        bus.o_valid   <= 1'b1;
        bus.o_overrun <= bus.o_valid && !bus.i_read;
      end else if (bus.i_read && bus.o_valid) begin
        bus.o_valid   <= 1'b0;
        bus.o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rxuart_fifo_free.sv
// tb/tb_rxuart_fifo_free.sv - directed self-checking bench for the UART receiver
module tb_rxuart_fifo_free;

  localparam real CLK_P = 10.0;
  localparam real BT    = CLK_P * 16.0e6 / 115200.0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic read_main = 1'b0;
  logic read_auto = 1'b0;
  logic read_sync = 1'b0;
  logic auto_read = 1'b0;
  logic sync_read = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  int ferr_rises = 0;
  int ferr_cycles = 0;
  int valid_cycles = 0;
  int busy_cycles = 0;
  int ovr_cycles = 0;
  int cap_n = 0;
  logic [7:0] cap [64];
  real valid_rise_t = -1.0;
  real busy_fall_t = -2.0;
  real t_stop = 0.0;
  logic prev_valid = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_ferr = 1'b0;

  logic [7:0] msg [15] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h2c, 8'h20,
                           8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h20, 8'h00};

  rxuart_fifo_free_if bus ();

  assign bus.i_read = read_main | read_auto | read_sync;

  rxuart_fifo_free dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_uart_rx (rx),
    .bus       (bus)
  );

  always #(CLK_P / 2.0) clk = ~clk;

  // Observer and automatic consumer, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.o_frame_err) begin
      ferr_cycles++;
      if (!prev_ferr) ferr_rises++;
    end
    if (bus.o_valid) valid_cycles++;
    if (bus.o_valid && !prev_valid) valid_rise_t = $realtime;
    if (!bus.o_busy && prev_busy) busy_fall_t = $realtime;
    if (bus.o_busy) busy_cycles++;
    if (bus.o_overrun) ovr_cycles++;
    if (auto_read && bus.o_valid && !read_auto) begin
      cap[cap_n % 64] = bus.o_data;
      cap_n++;
      read_auto = 1'b1;
    end else begin
      read_auto = 1'b0;
    end
    read_sync = sync_read && dut.deliver;
    prev_valid = bus.o_valid;
    prev_busy  = bus.o_busy;
    prev_ferr  = bus.o_frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input real bt);
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bt);
    end
    t_stop = $realtime;
    rx = stop;
    #(bt);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    read_main = 1'b1;
    @(negedge clk);
    read_main = 1'b0;
  endtask

  initial begin
    int b0, v0, f0, fc0, o0, base, lat;
    real bt;
    logic [7:0] a5;
    a5 = 8'hA5;

    repeat (5) @(negedge clk);
    chk("rst_data", {24'd0, bus.o_data}, 32'h00);
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_ferr", {31'd0, bus.o_frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, bus.o_overrun}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send_byte(8'h48, 1'b1, BT);
    repeat (5) @(negedge clk);
    chk("h_data", {24'd0, bus.o_data}, 32'h48);
    chk("h_valid", {31'd0, bus.o_valid}, 32'd1);
    lat = int'((valid_rise_t - t_stop) / CLK_P);
    chk("h_latency_70_100", {31'd0, (lat >= 70 && lat <= 100)}, 32'd1);
    chk("h_busy_fall_with_valid", {31'd0, (busy_fall_t == valid_rise_t)}, 32'd1);
    read_pulse();
    chk("h_read_clears_valid", {31'd0, bus.o_valid}, 32'd0);

    b0 = busy_cycles; v0 = valid_cycles; f0 = ferr_rises;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (120) @(negedge clk);
    chk("glitch_busy_window", {31'd0, ((busy_cycles - b0) >= 70 && (busy_cycles - b0) <= 86)}, 32'd1);
    chk("glitch_no_valid", valid_cycles - v0, 32'd0);
    chk("glitch_no_ferr", ferr_rises - f0, 32'd0);
    chk("glitch_idle", {31'd0, bus.o_busy}, 32'd0);

    v0 = valid_cycles; f0 = ferr_rises; fc0 = ferr_cycles;
    send_byte(8'h55, 1'b0, BT);
    #(2.0 * BT);
    chk("ferr_one_pulse", ferr_rises - f0, 32'd1);
    chk("ferr_one_cycle", ferr_cycles - fc0, 32'd1);
    chk("ferr_no_valid", valid_cycles - v0, 32'd0);
    chk("ferr_data_kept", {24'd0, bus.o_data}, 32'h48);
    chk("ferr_busy_in_break", {31'd0, bus.o_busy}, 32'd1);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("ferr_idle_after_release", {31'd0, bus.o_busy}, 32'd0);
    send_byte(8'h55, 1'b1, BT);
    repeat (5) @(negedge clk);
    chk("after_ferr_data", {24'd0, bus.o_data}, 32'h55);
    chk("after_ferr_valid", {31'd0, bus.o_valid}, 32'd1);
    read_pulse();

    send_byte(8'h41, 1'b1, BT);
    send_byte(8'h42, 1'b1, BT);
    repeat (5) @(negedge clk);
    chk("ovr_data", {24'd0, bus.o_data}, 32'h42);
    chk("ovr_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("ovr_flag", {31'd0, bus.o_overrun}, 32'd1);
    read_pulse();
    chk("ovr_read_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("ovr_read_flag", {31'd0, bus.o_overrun}, 32'd0);

    send_byte(8'h41, 1'b1, BT);
    sync_read = 1'b1;
    send_byte(8'h42, 1'b1, BT);
    sync_read = 1'b0;
    repeat (5) @(negedge clk);
    chk("simul_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("simul_no_overrun", {31'd0, bus.o_overrun}, 32'd0);
    chk("simul_data", {24'd0, bus.o_data}, 32'h42);

    rx = 1'b0;
    #(BT);
    for (int i = 0; i < 3; i++) begin
      rx = a5[i];
      #(BT);
    end
    rx = a5[3];
    #(BT / 2.0);
    rst_n = 1'b0;
    #1;
    chk("mrst_data", {24'd0, bus.o_data}, 32'h00);
    chk("mrst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("mrst_ferr", {31'd0, bus.o_frame_err}, 32'd0);
    chk("mrst_overrun", {31'd0, bus.o_overrun}, 32'd0);
    chk("mrst_busy", {31'd0, bus.o_busy}, 32'd0);
    rx = 1'b1;
    #(2.0 * BT);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("mrst_no_delivery", {31'd0, bus.o_valid}, 32'd0);
    send_byte(8'h65, 1'b1, BT);
    repeat (5) @(negedge clk);
    chk("mrst_next_data", {24'd0, bus.o_data}, 32'h65);
    chk("mrst_next_valid", {31'd0, bus.o_valid}, 32'd1);
    read_pulse();

    for (int s = 0; s < 3; s++) begin
      bt = (s == 0) ? BT : ((s == 1) ? BT * 1.02 : BT * 0.98);
      base = cap_n; f0 = ferr_rises; o0 = ovr_cycles;
      auto_read = 1'b1;
      for (int i = 0; i < 15; i++) send_byte(msg[i], 1'b1, bt);
      repeat (100) @(negedge clk);
      auto_read = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("stream%0d_count", s), cap_n - base, 32'd15);
      for (int i = 0; i < 15; i++)
        chk($sformatf("stream%0d_byte%0d", s, i), {24'd0, cap[(base + i) % 64]}, {24'd0, msg[i]});
      chk($sformatf("stream%0d_ferr", s), ferr_rises - f0, 32'd0);
      chk($sformatf("stream%0d_overrun", s), ovr_cycles - o0, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
